// File: rtl/seq_shift_add_multiplier.sv
// Iterative 16x16 unsigned shift-add multiplier with a start/ready handshake.
// One partial-product step per clock through a 16-bit carry-select adder.

module carry_select_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);
  logic [4:0] carry;
  logic [4:0] r0;
  logic [4:0] r1;
  logic [4:0] sel;

  // Each 4-bit block precomputes both carry-in cases; the incoming carry picks one.
  always_comb begin
    carry    = '0;
    carry[0] = carry_in;
    sum      = '0;
    r0       = '0;
    r1       = '0;
    sel      = '0;
    for (int unsigned blk = 0; blk < 4; blk++) begin
      r0 = {1'b0, a[blk*4 +: 4]} + {1'b0, b[blk*4 +: 4]};
      r1 = r0 + 5'd1;
      sel = carry[blk] ? r1 : r0;
      sum[blk*4 +: 4] = sel[3:0];
      carry[blk+1]    = sel[4];
    end
    carry_out = carry[4];
  end
endmodule

module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ctrl_mult,
  input  logic                 ctrl_abort,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  output logic [2*WIDTH-1:0]   data_result,
  output logic                 data_resultRDY,
  output logic                 busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] step_prod;
  logic               start;
  logic               last_step;

  carry_select_adder u_adder (
    .a         (hi_q),
    .b         (addend),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (cout)
  );

  always_comb begin
    addend    = lo_q[0] ? mcand_q : '0;
    step_prod = {cout, sum, lo_q[WIDTH-1:1]};
    start     = ctrl_mult && !ctrl_abort && (state_q == IDLE || state_q == DONE);
    last_step = (state_q == RUN) && (count_q == 4'd15);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  // Abort dominates both a new start and completion on the final step.
  always_comb begin
    state_d = state_q;
    if (ctrl_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ctrl_mult ? RUN : IDLE;
        RUN:     state_d = (count_q == 4'd15) ? DONE : RUN;
        DONE:    state_d = ctrl_mult ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d  = count_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (ctrl_abort) begin
      count_d = '0;
    end else if (start) begin
      mcand_d = data_operandA;
      lo_d    = data_operandB;
      hi_d    = '0;
      count_d = '0;
    end else if (state_q == RUN) begin
      {hi_d, lo_d} = step_prod;
      count_d      = count_q + 4'd1;
      if (last_step) begin
        result_d = step_prod;
      end
    end
  end

  always_comb begin
    busy           = (state_q == RUN);
    data_resultRDY = (state_q == DONE);
    data_result    = result_q;
  end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed table, handshake
// corner sequences (back-to-back, abort, async reset) and randomized products.

module tb_seq_shift_add_multiplier;
  logic        clock;
  logic        reset_n;
  logic        ctrl_mult;
  logic        ctrl_abort;
  logic [15:0] data_operandA;
  logic [15:0] data_operandB;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int failures;

  seq_shift_add_multiplier #(.WIDTH(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_mult      (ctrl_mult),
    .ctrl_abort     (ctrl_abort),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller sits just after a negedge. Drives a start, optionally injects a
  // junk start mid-run, and on the RDY cycle optionally chains the next start.
  task automatic run_mult(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input int inject,
                          input bit chain, input logic [15:0] na, input logic [15:0] nb);
    int          cycles;
    int          busy_cnt;
    bit          stable;
    bit          seen;
    logic [31:0] prev;
    cycles   = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    prev     = data_result;
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    while (cycles < 40 && !seen) begin
      @(negedge clock);
      cycles++;
      ctrl_mult = 1'b0;
      if (data_resultRDY) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (data_result !== prev) stable = 1'b0;
        if (cycles == inject) begin
          ctrl_mult     = 1'b1;
          data_operandA = 16'h5A5A;
          data_operandB = 16'hC3C3;
        end
      end
    end
    check({name, " rdy_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(cycles - 1), 32'd16);
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({name, " result_stable"}, 32'(stable), 32'd1);
    check({name, " result"}, data_result, exp);
    check({name, " busy_in_done"}, 32'(busy), 32'd0);
    if (chain) begin
      data_operandA = na;
      data_operandB = nb;
      ctrl_mult     = 1'b1;
    end
  endtask

  task automatic idle_check(input string name, input logic [31:0] exp_res);
    @(negedge clock);
    check({name, " rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
    check({name, " idle_busy"}, 32'(busy), 32'd0);
    check({name, " result_held"}, data_result, exp_res);
  endtask

  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, input int n);
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ctrl_mult = 1'b0;
    end
  endtask

  initial begin
    int          rdy_cnt;
    logic [15:0] ra;
    logic [15:0] rb;
    checks   = 0;
    failures = 0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[4] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[5] = '{16'h8000, 16'h0002, 32'h00010000};

    reset_n       = 1'b0;
    ctrl_mult     = 1'b0;
    ctrl_abort    = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset result", data_result, 32'h0);
    check("reset rdy", 32'(data_resultRDY), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, '0, '0);
      idle_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Back-to-back: junk start mid-run is ignored, next start issued during DONE.
    run_mult("b2b_first", 16'h00FF, 16'h0101, 32'h0000FFFF, 6, 1'b1, 16'h0007, 16'h0009);
    run_mult("b2b_second", 16'h0007, 16'h0009, 32'h0000003F, 9, 1'b0, '0, '0);
    idle_check("b2b_second", 32'h0000003F);

    // Abort mid-run: no RDY, result keeps prior value.
    start_and_wait(16'h0005, 16'h0005, 8);
    ctrl_abort = 1'b1;
    @(negedge clock);
    ctrl_abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check("abort no_rdy", 32'(rdy_cnt), 32'd0);
    check("abort result_held", data_result, 32'h0000003F);

    // Abort coinciding with the completing edge wins.
    start_and_wait(16'h0011, 16'h0011, 16);
    ctrl_abort = 1'b1;
    @(negedge clock);
    ctrl_abort = 1'b0;
    check("abort_last rdy", 32'(data_resultRDY), 32'd0);
    check("abort_last busy", 32'(busy), 32'd0);
    check("abort_last result", data_result, 32'h0000003F);

    // Async reset mid-run: outputs clear before any clock edge.
    start_and_wait(16'hFFFF, 16'hFFFF, 6);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset result", data_result, 32'h0);
    check("async_reset busy", 32'(busy), 32'd0);
    check("async_reset rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset rdy", 32'(data_resultRDY), 32'd0);
    run_mult("fresh", 16'h8000, 16'h0002, 32'h00010000, 0, 1'b0, '0, '0);
    idle_check("fresh", 32'h00010000);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) ra = 16'hFFFF;
      if (i == 1) rb = 16'h0001;
      run_mult($sformatf("rand%0d", i), ra, rb, model(ra, rb), (i % 3 == 0) ? 5 : 0, 1'b0, '0, '0);
      if (i % 4 == 0) idle_check($sformatf("rand%0d", i), model(ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
